// File: rtl/kyber_prf_pkg.sv
// Shared constants and types for the Kyber PRF scheduling slice.
//   SEED_W/NONCE_W/M_W : PRF seed, nonce and message widths
//   Z_W/Z2_W           : full and short (eta2) PRF output widths
//   N_ETA1/N_ETA2      : SHAKE_256 n_num encodings for 1536/1024-bit output
//   prf_state_t        : scheduler FSM states
package kyber_prf_pkg;

   localparam int unsigned SEED_W  = 256;
   localparam int unsigned NONCE_W = 8;
   localparam int unsigned M_W     = 264;
   localparam int unsigned Z_W     = 1536;
   localparam int unsigned Z2_W    = 1024;
   localparam int unsigned ID_W    = 3;

   localparam logic [1:0] N_ETA1 = 2'd1;
   localparam logic [1:0] N_ETA2 = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_START,
      S_WAIT,
      S_DONE
   } prf_state_t;

endpackage

// File: rtl/prf_scheduler_if.sv
// Core-side and response-side bus of the PRF scheduler.
//   core_rst/core_active/core_M/core_n_num : scheduler -> SHAKE_256
//   core_finish/core_Z                     : SHAKE_256 -> scheduler
//   rsp_valid/rsp_id/rsp_data/rsp_err      : scheduler -> requester
//   rsp_ready                              : requester -> scheduler
// master = scheduler side, slave = core/requester environment side.
interface prf_scheduler_if;
   import kyber_prf_pkg::*;

   logic              core_rst;
   logic              core_active;
   logic [0:M_W-1]    core_M;
   logic [1:0]        core_n_num;
   logic              core_finish;
   logic [0:Z_W-1]    core_Z;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic [0:Z_W-1]    rsp_data;
   logic              rsp_err;

   modport master (
      output core_rst, core_active, core_M, core_n_num,
      input  core_finish, core_Z,
      output rsp_valid, rsp_id, rsp_data, rsp_err,
      input  rsp_ready
   );

   modport slave (
      input  core_rst, core_active, core_M, core_n_num,
      output core_finish, core_Z,
      input  rsp_valid, rsp_id, rsp_data, rsp_err,
      output rsp_ready
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : request vector (NREQ <= 8)
//   last_grant : index granted last time
//   grant      : first requesting index after last_grant, cyclically
//   found      : any request present
module rr_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0] req,
   input  logic [2:0]      last_grant,
   output logic [2:0]      grant,
   output logic            found
);

   // Two passes: indices above last_grant first, then wrap to the bottom.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && (i > 32'(last_grant)) && req[i]) begin
            grant = 3'(i);
            found = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req[i]) begin
            grant = 3'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prf_scheduler.sv
// Shares one SHAKE_256 PRF core among NREQ noise-sampling requesters.
// Arbitrates round-robin, builds M = seed || nonce, resets and launches the
// core, watches it with a watchdog and returns the left-aligned output.
//   clk, rst          : clock, synchronous active-low reset
//   req, req_n2       : per-requester request level and length select
//   seed              : PRF seed, sampled at grant
//   nonce_ld/nonce_in : nonce counter load (IDLE only)
//   nonce             : current nonce counter
//   busy              : FSM not idle
//   bus               : core control/data and response handshake
module prf_scheduler
   import kyber_prf_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     req_n2,
   input  logic [SEED_W-1:0]   seed,
   input  logic                nonce_ld,
   input  logic [NONCE_W-1:0]  nonce_in,
   output logic [NONCE_W-1:0]  nonce,
   output logic                busy,
   prf_scheduler_if.master     bus
);

   localparam logic [7:0]      TO_LIM    = 8'(TIMEOUT);
   localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NREQ - 1);

   prf_state_t          state, state_nx;
   logic [ID_W-1:0]     last_grant;
   logic [ID_W-1:0]     id_q;
   logic                n2_q;
   logic [0:M_W-1]      m_q;
   logic [7:0]          wd;
   logic [0:Z_W-1]      data_q;
   logic                err_q;
   logic [NONCE_W-1:0]  nonce_q;

   logic [ID_W-1:0]     grant;
   logic                found;
   logic [NREQ-1:0]     grant_oh;
   logic                n2_sel;
   logic                wd_hit;
   logic [0:Z_W-1]      z_cap;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req        (req),
      .last_grant (last_grant),
      .grant      (grant),
      .found      (found)
   );

   assign grant_oh = NREQ'(1) << grant;
   assign n2_sel   = |(req_n2 & grant_oh);

   // wd holds cycles already spent in WAIT; abort after the TIMEOUT-th one.
   assign wd_hit = (wd + 8'd1) == TO_LIM;

   // Short output arrives right-aligned from the core; move it to the left.
   assign z_cap = n2_q ? {bus.core_Z[Z_W-Z2_W +: Z2_W], {(Z_W-Z2_W){1'b0}}}
                       : bus.core_Z;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (!nonce_ld && found) state_nx = S_CLEAR;
         S_CLEAR: state_nx = S_START;
         S_START: state_nx = S_WAIT;
         S_WAIT:  if (bus.core_finish || wd_hit) state_nx = S_DONE;
         S_DONE:  if (bus.rsp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.core_rst    = !rst || (state == S_CLEAR);
      bus.core_active = (state == S_START);
      bus.rsp_valid   = (state == S_DONE);
      busy            = (state != S_IDLE);
      bus.core_M      = (state != S_IDLE) ? m_q : '0;
      bus.core_n_num  = (state == S_IDLE) ? 2'd0 : (n2_q ? N_ETA2 : N_ETA1);
   end

   // Job context, nonce counter, watchdog and response capture
   always_ff @(posedge clk) begin
      if (!rst) begin
         nonce_q    <= '0;
         last_grant <= LAST_INIT;
         id_q       <= '0;
         n2_q       <= 1'b0;
         m_q        <= '0;
         wd         <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (nonce_ld) begin
                  nonce_q <= nonce_in;
               end else if (found) begin
                  id_q <= grant;
                  n2_q <= n2_sel;
                  m_q  <= {seed, nonce_q};
               end
            end
            S_START: begin
               nonce_q <= nonce_q + 8'd1;
               wd      <= '0;
            end
            S_WAIT: begin
               wd <= wd + 8'd1;
               if (bus.core_finish) begin
                  data_q <= z_cap;
                  err_q  <= 1'b0;
               end else if (wd_hit) begin
                  data_q <= '0;
                  err_q  <= 1'b1;
               end
            end
            S_DONE: begin
               if (bus.rsp_ready) last_grant <= id_q;
            end
            default: ;
         endcase
      end
   end

   assign nonce        = nonce_q;
   assign bus.rsp_id   = id_q;
   assign bus.rsp_data = data_q;
   assign bus.rsp_err  = err_q;

endmodule
